lab00_inv_ctrl: RTL

//  Self-checking stimulus sequencer for the lab00 inverter datapath (i_x -> o_y).
//  On start it drives the inverter input with N timed toggles and samples the

---
 rtl/lab00_inv_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/lab00_inv_ctrl.sv
// Clocked stimulus sequencer for the lab00 inverter: drives N timed toggles on o_x,
// checks i_y against ~o_x before each toggle and once after the last, reports the result.
module lab00_inv_ctrl #(
  parameter int unsigned HALF_PERIOD = 5,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_toggles,
  output logic             o_x,
  input  logic             i_y,
  output logic             o_busy,
  output logic             o_done,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_pass
);

  localparam int unsigned       TimerW      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [TimerW-1:0] TimerReload = TimerW'(HALF_PERIOD - 1);
  localparam logic [ERR_W-1:0]  ErrMax      = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic                x_q, x_d;
  logic [CNT_W-1:0]    left_q, left_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                pass_q, pass_d;

  logic                mismatch;
  logic [ERR_W-1:0]    err_upd;

  always_comb begin
    // A good inverter returns ~x, so equality with x is a mismatch.
    mismatch = (i_y == x_q);
    err_upd  = (mismatch && (err_q != ErrMax)) ? err_q + ERR_W'(1) : err_q;

    state_d  = state_q;
    x_d      = x_q;
    left_d   = left_q;
    timer_d  = timer_q;
    err_d    = err_q;
    pass_d   = pass_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          x_d    = 1'b0;
          err_d  = '0;
          left_d = i_num_toggles;
          // A zero-length run performs no checks and therefore cannot fail.
          pass_d = (i_num_toggles == '0);
          if (i_num_toggles != '0) begin
            timer_d = TimerReload;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TimerW'(1);
        end else begin
          err_d = err_upd;
          if (left_q != '0) begin
            x_d     = ~x_q;
            left_d  = left_q - CNT_W'(1);
            timer_d = TimerReload;
          end else begin
            pass_d  = (err_upd == '0);
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      x_q     <= 1'b0;
      left_q  <= '0;
      timer_q <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      left_q  <= left_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign o_x       = x_q;
  assign o_busy    = (state_q == StRun);
  assign o_done    = (state_q == StDone);
  assign o_err_cnt = err_q;
  assign o_pass    = pass_q;

endmodule
